calculate_n_obf_seq: RTL and testbench

Parametrised, sequential successor to the combinational locked constant multiplier: computes `ap_return = a * K` mod 2^WIDTH. K is a secret constant recovered only with the correct key: `K = CONST_ENC ^ locking_key[WIDTH:1]`. It uses an iterative shift-add datapath (one multiplier bit per cycle) behind the ap_ block-level handshake, so area stays small for wide WIDTH. It sits in the locked-ALU datapath wherever a keyed multiply-by-constant is needed and throughput of one result per WIDTH+2 cycles is acceptable.

---
 rtl/calculate_obf_pkg.sv | 18 +
 rtl/calculate_n_obf_seq_if.sv | 26 ++
 rtl/calculate_obf_shift_add.sv | 62 ++++++
 rtl/calculate_n_obf_seq.sv | 98 +++++++++
 tb/tb_calculate_n_obf_seq.sv | 170 +++++++++++++++++
 5 files changed

// File: rtl/calculate_obf_pkg.sv
// Shared types and constants for the keyed sequential constant multiplier.
package calculate_obf_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  // Encrypted constant shipped with the block; the correct key recovers the designer's K.
  localparam logic [31:0] DefaultConstEnc = 32'hE9AA4AB3;

  // Number of low key bits that carry meaning: bit 0 for the idle lock, bits [width:1] for K.
  function automatic int unsigned key_slice_w(input int unsigned width);
    return width + 1;
  endfunction

endpackage

// File: rtl/calculate_n_obf_seq_if.sv
// ap_ block-level handshake plus operand, result and key buses.
interface calculate_n_obf_seq_if #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned KEY_W = 255
);

  logic             ap_start;
  logic             ap_done;
  logic             ap_idle;
  logic             ap_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic [WIDTH-1:0] ap_return;
  logic [KEY_W-1:0] locking_key;

  modport master (
    output ap_start, a, b, locking_key,
    input  ap_done, ap_idle, ap_ready, ap_return
  );

  modport slave (
    input  ap_start, a, b, locking_key,
    output ap_done, ap_idle, ap_ready, ap_return
  );

endinterface

// File: rtl/calculate_obf_shift_add.sv
// Iterative shift-add multiplier datapath: one multiplier bit consumed per step.
module calculate_obf_shift_add #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             load_i,
  input  logic             step_i,
  input  logic [WIDTH-1:0] mcand_i,
  input  logic [WIDTH-1:0] mplier_i,
  output logic [WIDTH-1:0] acc_next_o,
  output logic             last_o
);

  localparam int unsigned CntW = $clog2(WIDTH);

  logic [WIDTH-1:0] mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [CntW-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_next;

  // Load operands at accept, otherwise advance one partial product per step.
  always_comb begin
    acc_next = acc_q + (mplier_q[0] ? mcand_q : '0);
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    if (load_i) begin
      mcand_d  = mcand_i;
      mplier_d = mplier_i;
      acc_d    = '0;
      cnt_d    = '0;
    end else if (step_i) begin
      acc_d    = acc_next;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + CntW'(1);
    end
  end

  // Datapath registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else begin
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
    end
  end

  assign acc_next_o = acc_next;
  // High during the final step; acc_next_o then holds the complete truncated product.
  assign last_o     = (cnt_q == CntW'(WIDTH - 1));

endmodule

// File: rtl/calculate_n_obf_seq.sv
// Keyed multiply-by-constant with ap_ handshake: ap_return = a * K mod 2^WIDTH,
// K = CONST_ENC ^ locking_key[WIDTH:1]; a wrong key bit 0 inverts ap_idle.
module calculate_n_obf_seq
  import calculate_obf_pkg::*;
#(
  parameter int unsigned      WIDTH     = 32,
  parameter int unsigned      KEY_W     = 255,
  parameter logic [WIDTH-1:0] CONST_ENC = WIDTH'(DefaultConstEnc)
) (
  input logic                  ap_clk,
  input logic                  ap_rst_n,
  calculate_n_obf_seq_if.slave bus
);

  localparam int unsigned KeySliceW = key_slice_w(WIDTH);

  state_e           state_q, state_d;
  logic             kbit0_q, kbit0_d;
  logic             accepted_q, accepted_d;
  logic [WIDTH-1:0] ret_q, ret_d;
  logic             load, step, last;
  logic [WIDTH-1:0] acc_next;
  logic [KeySliceW-1:0] key_slice;
  logic [WIDTH-1:0] mplier_init;
  logic             kbit_eff;
  logic             unused_inputs;

  assign key_slice   = bus.locking_key[KeySliceW-1:0];
  assign mplier_init = CONST_ENC ^ key_slice[KeySliceW-1:1];

  // b and the upper key bits exist only for port compatibility.
  assign unused_inputs = ^{bus.b, bus.locking_key};

  // FSM next state, datapath controls and key/result latches.
  always_comb begin
    state_d    = state_q;
    kbit0_d    = kbit0_q;
    accepted_d = accepted_q;
    ret_d      = ret_q;
    load       = 1'b0;
    step       = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.ap_start) begin
          load       = 1'b1;
          kbit0_d    = key_slice[0];
          accepted_d = 1'b1;
          state_d    = StRun;
        end
      end
      StRun: begin
        step = 1'b1;
        if (last) begin
          ret_d   = acc_next;
          state_d = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Control state registers.
  always_ff @(posedge ap_clk or negedge ap_rst_n) begin
    if (!ap_rst_n) begin
      state_q    <= StIdle;
      kbit0_q    <= 1'b0;
      accepted_q <= 1'b0;
      ret_q      <= '0;
    end else begin
      state_q    <= state_d;
      kbit0_q    <= kbit0_d;
      accepted_q <= accepted_d;
      ret_q      <= ret_d;
    end
  end

  calculate_obf_shift_add #(
    .WIDTH (WIDTH)
  ) u_shift_add (
    .clk_i      (ap_clk),
    .rst_ni     (ap_rst_n),
    .load_i     (load),
    .step_i     (step),
    .mcand_i    (bus.a),
    .mplier_i   (mplier_init),
    .acc_next_o (acc_next),
    .last_o     (last)
  );

  // Before any accept there is no latched bit, so the live key bit drives the idle lock.
  assign kbit_eff      = accepted_q ? kbit0_q : key_slice[0];
  assign bus.ap_idle   = (state_q == StIdle) ^ kbit_eff;
  assign bus.ap_done   = (state_q == StDone);
  assign bus.ap_ready  = (state_q == StDone);
  assign bus.ap_return = ret_q;

endmodule

// File: tb/tb_calculate_n_obf_seq.sv
// Directed self-checking bench for calculate_n_obf_seq (WIDTH=32).
module tb_calculate_n_obf_seq;

  localparam int unsigned W  = 32;
  localparam int unsigned KW = 255;

  logic ap_clk = 1'b0;
  logic ap_rst_n = 1'b0;
  int   checks = 0;
  int   errors = 0;

  always #5 ap_clk = ~ap_clk;

  calculate_n_obf_seq_if #(.WIDTH(W), .KEY_W(KW)) bus ();

  calculate_n_obf_seq #(
    .WIDTH     (W),
    .KEY_W     (KW),
    .CONST_ENC (32'hE9AA4AB3)
  ) dut (
    .ap_clk   (ap_clk),
    .ap_rst_n (ap_rst_n),
    .bus      (bus)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [KW-1:0] rand_key();
    logic [255:0] t;
    t = {$urandom(), $urandom(), $urandom(), $urandom(),
         $urandom(), $urandom(), $urandom(), $urandom()};
    return t[KW-1:0];
  endfunction

  // mode 0: inputs steady; 1: b randomised each cycle; 2: a, b and key randomised each cycle.
  task automatic run_op(input string tag, input logic [W-1:0] a_v, input logic [KW-1:0] key_v,
                        input logic [W-1:0] exp_ret, input int mode);
    int n;
    bit seen;
    n = 0;
    seen = 1'b0;
    @(negedge ap_clk);
    bus.a = a_v;
    bus.locking_key = key_v;
    bus.ap_start = 1'b1;
    if (mode != 0) bus.b = $urandom();
    while (!seen && n < 100) begin
      @(posedge ap_clk);
      n++;
      #1;
      if (n == 1) begin
        bus.ap_start = 1'b0;
        check({tag, " idle_run"}, {63'd0, bus.ap_idle}, {63'd0, key_v[0]});
      end
      if (bus.ap_done) seen = 1'b1;
      if (mode != 0) bus.b = $urandom();
      if (mode == 2) begin
        bus.a = $urandom();
        bus.locking_key = rand_key();
      end
    end
    check({tag, " latency"}, 64'(n), 64'(W + 1));
    check({tag, " ret"}, {32'd0, bus.ap_return}, {32'd0, exp_ret});
    check({tag, " ready"}, {63'd0, bus.ap_ready}, 64'd1);
    @(posedge ap_clk);
    #1;
    check({tag, " done_pulse"}, {63'd0, bus.ap_done}, 64'd0);
    check({tag, " idle_after"}, {63'd0, bus.ap_idle}, {63'd0, ~key_v[0]});
    check({tag, " ret_hold"}, {32'd0, bus.ap_return}, {32'd0, exp_ret});
  endtask

  initial begin
    int n;
    int n1;
    bit seen;
    bus.ap_start = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.locking_key = '0;

    // Reset values with live key bit 0.
    #1;
    check("rst done", {63'd0, bus.ap_done}, 64'd0);
    check("rst ready", {63'd0, bus.ap_ready}, 64'd0);
    check("rst ret", {32'd0, bus.ap_return}, 64'd0);
    check("rst idle k0", {63'd0, bus.ap_idle}, 64'd1);
    bus.locking_key = KW'(1);
    #1;
    check("rst idle k1", {63'd0, bus.ap_idle}, 64'd0);
    bus.locking_key = '0;
    repeat (2) @(negedge ap_clk);
    ap_rst_n = 1'b1;
    @(posedge ap_clk);
    #1;
    check("idle pre", {63'd0, bus.ap_idle}, 64'd1);

    // Zero key exposes CONST_ENC itself.
    run_op("k0 a1", 32'd1, KW'(0), 32'hE9AA4AB3, 0);
    // key[32:1] = 0xE9AA4AB0 gives K = 3.
    run_op("k3 a5", 32'd5, KW'(33'h1D3549560), 32'h0000000F, 0);
    run_op("k3 trunc", 32'hFFFFFFFF, KW'(33'h1D3549560), 32'hFFFFFFFD, 0);
    run_op("k0 a2 b", 32'd2, KW'(0), 32'hD3549566, 1);
    // 3 * 0xE9AA4AB3 = 0x2BCFEE019, truncated.
    run_op("k0 a3 scr", 32'd3, KW'(0), 32'hBCFEE019, 2);
    // Wrong bit 0: idle inverted, product unaffected (3*7).
    run_op("k3 bit0", 32'd7, KW'(33'h1D3549561), 32'h00000015, 0);

    // Asynchronous reset mid-RUN.
    @(negedge ap_clk);
    bus.a = 32'd1;
    bus.locking_key = '0;
    bus.ap_start = 1'b1;
    @(posedge ap_clk);
    #1;
    bus.ap_start = 1'b0;
    repeat (10) @(posedge ap_clk);
    #3;
    ap_rst_n = 1'b0;
    #1;
    check("mid rst done", {63'd0, bus.ap_done}, 64'd0);
    check("mid rst ready", {63'd0, bus.ap_ready}, 64'd0);
    check("mid rst ret", {32'd0, bus.ap_return}, 64'd0);
    check("mid rst idle", {63'd0, bus.ap_idle}, 64'd1);
    seen = 1'b0;
    repeat (3) begin
      @(posedge ap_clk);
      #1;
      if (bus.ap_done) seen = 1'b1;
    end
    check("mid rst no done", {63'd0, seen}, 64'd0);

    // Release with start held high: two back-to-back results.
    @(negedge ap_clk);
    ap_rst_n = 1'b1;
    bus.a = 32'd5;
    bus.locking_key = KW'(33'h1D3549560);
    bus.ap_start = 1'b1;
    n = 0;
    seen = 1'b0;
    while (!seen && n < 100) begin
      @(posedge ap_clk);
      n++;
      #1;
      if (bus.ap_done) seen = 1'b1;
    end
    check("b2b first lat", 64'(n), 64'(W + 1));
    check("b2b first ret", {32'd0, bus.ap_return}, 64'h0000000F);
    n1 = n;
    seen = 1'b0;
    while (!seen && n < 200) begin
      @(posedge ap_clk);
      n++;
      #1;
      if (bus.ap_done) seen = 1'b1;
    end
    bus.ap_start = 1'b0;
    check("b2b period", 64'(n - n1), 64'(W + 2));
    check("b2b second ret", {32'd0, bus.ap_return}, 64'h0000000F);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
